seq_detect_prog: RTL

Parametrised serial pattern detector: the next generation of the fixed-pattern `1011` detector. It supports runtime-programmable pattern and length up to `MAX_LEN` bits, selectable overlapping or non-overlapping matching, a valid qualifier on the input bit, and a saturating match counter. It sits on a serial bit stream in the same position as the fixed detector and is a drop-in superset: at reset it detects `1011`, overlapping.

---
 rtl/seq_detect_prog.sv | 64 ++++++
 1 files changed

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial pattern detector with overlap mode and saturating match count
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b1011,
    parameter logic [LEN_W-1:0]   DEF_LEN     = 4,
    parameter logic               DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_bit,
    input  logic               inp_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);
    logic [MAX_LEN-1:0] pat_q, hist, hist_next, mask;
    logic [LEN_W-1:0]   len_q, fill, fill_next;
    logic               ovl_q, match;

    // post-shift history, length mask and match decision for the bit being sampled
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len_q);
        cfg_err   = (len_q < LEN_W'(2)) || (int'(len_q) > MAX_LEN);
        hist_next = {hist[MAX_LEN-2:0], inp_bit};
        fill_next = (int'(fill) == MAX_LEN) ? fill : fill + 1'b1;
        match     = inp_valid && !cfg_load && !cfg_err && fill_next >= len_q
                    && ((hist_next ^ pat_q) & mask) == '0;
    end

    // config latch, history/fill tracking and registered match outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q       <= DEF_PATTERN;
            len_q       <= DEF_LEN;
            ovl_q       <= DEF_OVERLAP;
            hist        <= '0;
            fill        <= '0;
            seq_seen    <= 1'b0;
            match_count <= '0;
        end else if (cfg_load) begin
            pat_q       <= cfg_pattern;
            len_q       <= cfg_len;
            ovl_q       <= cfg_overlap;
            hist        <= '0;
            fill        <= '0;
            seq_seen    <= 1'b0;
            match_count <= '0;
        end else if (inp_valid) begin
            hist        <= hist_next;
            fill        <= (match && !ovl_q) ? '0 : fill_next;
            seq_seen    <= match;
            match_count <= (match && !(&match_count)) ? match_count + 1'b1 : match_count;
        end else begin
            seq_seen    <= 1'b0;
        end
    end
endmodule
